// File: rtl/instr_encoder_pkg.sv
// Shared format classes, opcodes and the field-packing helpers for instr_encoder.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      FMT_R      = 3'd0,
      FMT_I      = 3'd1,
      FMT_LOAD   = 3'd2,
      FMT_STORE  = 3'd3,
      FMT_BRANCH = 3'd4
   } fmt_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [2:0]  typ;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } req_t;

   function automatic logic fmt_legal(input logic [2:0] t);
      return t <= 3'(FMT_BRANCH);
   endfunction

   // The immediate survives 12-bit packing only if bits 31:11 are a pure sign extension.
   function automatic logic imm_fits(input logic [31:0] imm);
      return (&imm[31:11]) | ~(|imm[31:11]);
   endfunction

   // BRANCH imm is already the halfword offset, so imm[11:0] map straight onto B-type slots.
   function automatic logic [31:0] encode(input req_t r);
      logic [31:0] w;
      w = '0;
      case (r.typ)
         3'(FMT_R):      w = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, OP_R};
         3'(FMT_I):      w = {r.imm[11:0], r.rs1, r.funct3, r.rd, OP_I};
         3'(FMT_LOAD):   w = {r.imm[11:0], r.rs1, r.funct3, r.rd, OP_LOAD};
         3'(FMT_STORE):  w = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], OP_STORE};
         3'(FMT_BRANCH): w = {r.imm[11], r.imm[9:4], r.rs2, r.rs1, r.funct3,
                              r.imm[3:0], r.imm[10], OP_BRANCH};
         default:        w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular buffer of encoded instructions; pointers wrap modulo FIFO_DEPTH (need not be a power of two).
module instr_fifo #(
   parameter int FIFO_DEPTH = 2,
   parameter int WIDTH      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= inc(wr_ptr);
         if (pop)  rd_ptr <= inc(rd_ptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: nothing is visible while the occupancy count is zero.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (cnt == CW'(FIFO_DEPTH));
   assign empty = (cnt == '0);

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit RV32 words behind a small output FIFO.
// Optional IMM_RANGE_CHECK_EN drops non-R requests whose immediate does not fit 12 bits.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [2:0]  type_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] instr_o,
   output logic        err_o,
   output logic [15:0] count_o
);

   req_t        req;
   logic        full, empty, push, pop, accept, drop;
   logic        err_q;
   logic [15:0] cnt_q;

   assign req = '{typ: type_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                  funct3: funct3_i, funct7: funct7_i, imm: imm_i};

   assign pop        = ~empty & out_ready_i;
   assign in_ready_o = ~rst_i & (~full | pop);
   assign accept     = in_valid_i & in_ready_o;

`ifdef IMM_RANGE_CHECK_EN
   assign drop = ~fmt_legal(type_i) | ((type_i != 3'(FMT_R)) & ~imm_fits(imm_i));
`else
   assign drop = ~fmt_legal(type_i);
`endif

   assign push = accept & ~drop;

   instr_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (32)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .wdata (encode(req)),
      .pop   (pop),
      .rdata (instr_o),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= accept & drop;
         if (pop) cnt_q <= cnt_q + 16'd1;
      end
   end

   assign out_valid_o = ~empty;
   assign err_o       = err_q;
   assign count_o     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, illegal drops and reset flush.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, err;
   logic [2:0]  typ, funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [6:0]  funct7;
   logic [31:0] imm, instr;
   logic [15:0] count;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   instr_encoder #(.FIFO_DEPTH(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .type_i      (typ),
      .rd_i        (rd),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .funct3_i    (funct3),
      .funct7_i    (funct7),
      .imm_i       (imm),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .instr_o     (instr),
      .err_o       (err),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] t, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] im);
      typ = t; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
   endtask

   // One-cycle request, then valid drops
   task automatic send(input logic [2:0] t, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
      set_req(t, d, s1, s2, f3, f7, im);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop_one(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_cnt++;
      chk({tag, "_cnt"}, 32'(count), 32'(exp_cnt));
      chk({tag, "_empty"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      step(); step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // addi x1, x0, 5
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      chk("i_valid", 32'(out_valid), 32'd1);
      chk("i_instr", instr, 32'h00500093);
      step();
      chk("i_hold", instr, 32'h00500093);
      pop_one("i");

      send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
      chk("store_instr", instr, 32'h0020A423);
      pop_one("store");

      send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4);
      chk("branch_instr", instr, 32'h00208463);
      pop_one("branch");

      // sub x3, x1, x2 with garbage imm that must be ignored
      send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF);
      chk("r_instr", instr, 32'h402081B3);
      chk("r_err", 32'(err), 32'd0);
      pop_one("r");

      // lw x5, -4(x2)
      send(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFFC);
      chk("load_instr", instr, 32'hFFC12283);
      pop_one("load");

      // bne x0, x0, -4 bytes (halfword offset -2)
      send(3'd4, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0, 32'hFFFF_FFFE);
      chk("branch_neg", instr, 32'hFE001EE3);
      pop_one("branch_neg");

      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
`ifdef IMM_RANGE_CHECK_EN
      chk("range_err", 32'(err), 32'd1);
      chk("range_no_out", 32'(out_valid), 32'd0);
      step();
      chk("range_err_end", 32'(err), 32'd0);
      chk("range_cnt", 32'(count), 32'(exp_cnt));
`else
      chk("range_err", 32'(err), 32'd0);
      chk("range_out", 32'(out_valid), 32'd1);
      chk("range_instr", instr, 32'h80000093);
      pop_one("range");
`endif

      // Illegal type with one legal entry already buffered
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      send(3'd6, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'd9);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_head", instr, 32'h00100093);
      chk("ill_cnt", 32'(count), 32'(exp_cnt));
      step();
      chk("ill_err_end", 32'(err), 32'd0);
      pop_one("ill");

      // Backpressure: 3 back-to-back requests into a 2-deep FIFO
      set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      in_valid = 1'b1;
      step();
      chk("bp_ready1", 32'(in_ready), 32'd1);
      set_req(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      step();
      chk("bp_full", 32'(in_ready), 32'd0);
      set_req(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      step();
      chk("bp_stall", 32'(in_ready), 32'd0);
      chk("bp_head_a", instr, 32'h00100093);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_pop", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_head_b", instr, 32'h00200113);
      step();
      chk("bp_head_c", instr, 32'h00300193);
      step();
      out_ready = 1'b0;
      exp_cnt += 3;
      chk("bp_drained", 32'(out_valid), 32'd0);
      chk("bp_cnt", 32'(count), 32'(exp_cnt));

      // Reset with 2 entries buffered
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      send(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      chk("mid_full", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_cnt", 32'(count), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", 32'(in_ready), 32'd1);
      chk("mid_rel_cnt", 32'(count), 32'd0);
      chk("mid_rel_valid", 32'(out_valid), 32'd0);
      exp_cnt = 0;
      send(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      chk("after_rst_instr", instr, 32'h00300193);
      pop_one("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the number of encoded-instruction entries buffered before in_ready_o deasserts (legal values 2..8).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid_i, input, 1 bit: request valid.
REQ-005 The block SHALL have port in_ready_o, output, 1 bit: request accepted when high together with in_valid_i at a clk_i rising edge.
REQ-006 The block SHALL have port type_i, input, 3 bits: format class (0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH; 5-7 illegal).
REQ-007 The block SHALL have ports rd_i, rs1_i and rs2_i, each an input of 5 bits: register indices.
REQ-008 The block SHALL have ports funct3_i (input, 3 bits) and funct7_i (input, 7 bits).
REQ-009 The block SHALL have port imm_i, input, 32 bits: sign-extended immediate; for BRANCH it is the halfword offset (byte offset >> 1), pre-shift.
REQ-010 The block SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1) and instr_o (output, 32 bits): the encoded-instruction stream.
REQ-011 The block SHALL have port err_o, output, 1 bit: one-cycle pulse flagging a dropped request.
REQ-012 The block SHALL have port count_o, output, 16 bits: number of instructions delivered on the output.

Function
REQ-013 Opcode SHALL be 0110011 for R, 0010011 for I, 0000011 for LOAD, 0100011 for STORE and 1100011 for BRANCH.
REQ-014 R SHALL encode {funct7, rs2, rs1, funct3, rd, op}; imm_i SHALL be ignored.
REQ-015 I and LOAD SHALL encode {imm[11:0], rs1, funct3, rd, op}.
REQ-016 STORE SHALL encode {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
REQ-017 BRANCH SHALL place imm[11] at bit 31, imm[10] at bit 7, imm[9:4] at bits 30:25 and imm[3:0] at bits 11:8, with rs2, rs1 and funct3 at the standard positions.
REQ-018 The immediate SHALL round-trip: for every non-R accepted request, decoding instr_o back to a 32-bit sign-extended immediate SHALL yield imm_i.
REQ-019 An accepted legal request SHALL be pushed into the FIFO; instr_o and out_valid_o SHALL present the FIFO head.
REQ-020 Latency SHALL be 1 cycle: a request accepted at edge N with an empty FIFO SHALL give out_valid_o high after edge N.
REQ-021 A head entry SHALL pop at each edge where out_valid_o and out_ready_i are both high.
REQ-022 in_ready_o SHALL be high when the FIFO is not full or a pop occurs in the same cycle (simultaneous push and pop at full is allowed).
REQ-023 instr_o and out_valid_o SHALL hold stable while out_valid_o is high and out_ready_i is low.
REQ-024 A type_i value of 5-7 on an accepted request SHALL drop that request and pulse err_o high for the cycle after acceptance.
REQ-025 count_o SHALL increment once per pop and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 While rst_i is high the FIFO SHALL be emptied and out_valid_o, err_o and count_o SHALL be 0.
REQ-028 in_ready_o SHALL be 0 while rst_i is high and SHALL be 1 on the first cycle after release.
REQ-029 Reset asserted mid-stream SHALL discard all buffered entries without popping them and without incrementing count_o.

Configuration
REQ-030 With IMM_RANGE_CHECK_EN defined, a non-R request whose imm_i[31:11] are not all equal SHALL be dropped and SHALL pulse err_o.
REQ-031 Without IMM_RANGE_CHECK_EN, such a request SHALL be encoded using imm_i[11:0] silently, and err_o SHALL fire only for illegal type_i.

Structure
REQ-032 The opcode constants and the type_i class encodings SHALL reside in the shared package/defines used by the decoder side.
REQ-033 The FIFO SHALL be a sub-module named instr_fifo, parameterised by FIFO_DEPTH and data width 32.

Verification
REQ-034 The bench SHALL check that I, rd=1, rs1=0, funct3=0, imm=5 gives instr_o=0x00500093 on the cycle after acceptance.
REQ-035 The bench SHALL check that STORE, rs1=1, rs2=2, funct3=2, imm=8 gives 0x0020A423, and that BRANCH, rs1=1, rs2=2, funct3=0, imm=4 gives 0x00208463.
REQ-036 The bench SHALL check that I with imm=0x00000800 gives an err_o pulse and no output when IMM_RANGE_CHECK_EN is defined, and gives instr_o with bits 31:20 = 0x800 when it is not defined.
REQ-037 The bench SHALL check, with out_ready_i=0, that 3 back-to-back requests leave in_ready_o low after 2 accepts; raising out_ready_i SHALL then deliver all 3 in order and leave count_o=3.
REQ-038 The bench SHALL check that type_i=6 gives an err_o pulse for one cycle and leaves the FIFO and count_o unchanged.
REQ-039 The bench SHALL check that asserting rst_i with 2 entries buffered drops out_valid_o immediately and leaves count_o=0 and in_ready_o=1 after release.
